// File: rtl/pattern_select_ctrl.sv
// Frame-synchronous pattern selector for the VGA 4:1 colour mux, with debounced
// next/prev buttons and a registered, blanking-gated colour output.
// Optional auto-slideshow timer is built only when AUTO_CYCLE_EN is defined.
module pattern_select_ctrl #(
  parameter int DATA_WIDTH       = 24,
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter int FRAMES_PER_SLIDE = 120
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_next,
  input  logic                  btn_prev,
  input  logic                  frame_start,
  input  logic                  video_on,
  input  logic                  auto_en,
  input  logic [DATA_WIDTH-1:0] color_in,
  output logic [1:0]            selection,
  output logic                  pending,
  output logic                  switched,
  output logic [DATA_WIDTH-1:0] color_out
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [1:0] delta_q, delta_d;
  logic [1:0] selection_q, selection_d;
  logic [DATA_WIDTH-1:0] color_q, color_d;

  logic [1:0] btn_raw;
  logic [1:0] btn_rise;
  logic       auto_req;
  logic       next_req;
  logic       prev_req;
  logic       req_valid;
  logic [1:0] req_delta;

  assign btn_raw = {btn_prev, btn_next};

  // Lane 0 = next, lane 1 = prev. Count cycles where the synced level disagrees
  // with the accepted level; a single agreeing sample restarts the count.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic          s1_q, s2_q;
      logic          level_q, level_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          rise;

      always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise    = 1'b0;
        if (s2_q != level_q) begin
          if (cnt_q == DB_LAST) begin
            level_d = s2_q;
            rise    = s2_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          s1_q    <= 1'b0;
          s2_q    <= 1'b0;
          level_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          s1_q    <= btn_raw[gi];
          s2_q    <= s1_q;
          level_q <= level_d;
          cnt_q   <= cnt_d;
        end
      end

      assign btn_rise[gi] = rise;
    end
  endgenerate

`ifdef AUTO_CYCLE_EN
  localparam int FW = ($clog2(FRAMES_PER_SLIDE + 1) > 8) ? $clog2(FRAMES_PER_SLIDE + 1) : 8;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SLIDE - 1);

  logic [FW-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    auto_req    = 1'b0;
    if (!auto_en || (|btn_rise)) begin
      frame_cnt_d = '0;
    end else if (frame_start && (state_q == ST_IDLE)) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        auto_req    = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end
`else
  logic unused_auto_en;
  assign unused_auto_en = auto_en;
  assign auto_req       = 1'b0;
`endif

  // Simultaneous +1 and -1 cancel out, so only one direction raises a request.
  assign next_req  = btn_rise[0] | auto_req;
  assign prev_req  = btn_rise[1];
  assign req_valid = next_req ^ prev_req;
  assign req_delta = next_req ? 2'd1 : 2'd3;

  always_comb begin
    state_d     = state_q;
    delta_d     = delta_q;
    selection_d = selection_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_WAIT;
          delta_d = req_delta;
        end
      end
      ST_WAIT: begin
        if (req_valid) delta_d = req_delta;
        if (frame_start) begin
          selection_d = selection_q + delta_d;
          state_d     = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (req_valid) begin
          state_d = ST_WAIT;
          delta_d = req_delta;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign color_d = video_on ? color_in : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      delta_q     <= 2'd0;
      selection_q <= 2'd0;
      color_q     <= '0;
    end else begin
      state_q     <= state_d;
      delta_q     <= delta_d;
      selection_q <= selection_d;
      color_q     <= color_d;
    end
  end

  assign selection = selection_q;
  assign pending   = (state_q == ST_WAIT);
  assign switched  = (state_q == ST_COMMIT);
  assign color_out = color_q;

endmodule

// File: tb/tb_pattern_select_ctrl.sv
// Self-checking bench for pattern_select_ctrl (DEBOUNCE_CYCLES=4, FRAMES_PER_SLIDE=3).
module tb_pattern_select_ctrl;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          btn_next, btn_prev, frame_start, video_on, auto_en;
  logic [DW-1:0] color_in;
  logic [1:0]    selection;
  logic          pending, switched;
  logic [DW-1:0] color_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          vid;
    logic [DW-1:0] cin;
    logic [DW-1:0] exp;
  } cvec_t;

  cvec_t         vecs[6];
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] exp_c;
  logic [1:0]    exp_sel;

  always #5 clk = ~clk;

  pattern_select_ctrl #(
    .DATA_WIDTH(DW),
    .DEBOUNCE_CYCLES(4),
    .FRAMES_PER_SLIDE(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_next(btn_next),
    .btn_prev(btn_prev),
    .frame_start(frame_start),
    .video_on(video_on),
    .auto_en(auto_en),
    .color_in(color_in),
    .selection(selection),
    .pending(pending),
    .switched(switched),
    .color_out(color_out)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("check %s: %0h ok", name, act);
    end
  endtask

  task automatic press(input logic nx, input logic pv, input int hold);
    btn_next = nx;
    btn_prev = pv;
    tick(hold);
    btn_next = 1'b0;
    btn_prev = 1'b0;
    tick(8);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic commit_frame(input string name, input logic [1:0] exp_s);
    pulse_frame();
    chk({name, "_sel"}, 32'(selection), 32'(exp_s));
    chk({name, "_switched"}, 32'(switched), 32'd1);
    tick(1);
    chk({name, "_switched_end"}, 32'(switched), 32'd0);
    chk({name, "_pending_end"}, 32'(pending), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{vid: 1'b1, cin: 24'hFF8000, exp: 24'hFF8000};
    vecs[1] = '{vid: 1'b0, cin: 24'hFF8000, exp: 24'h000000};
    vecs[2] = '{vid: 1'b1, cin: 24'h00FF00, exp: 24'h00FF00};
    vecs[3] = '{vid: 1'b1, cin: 24'hABCDEF, exp: 24'hABCDEF};
    vecs[4] = '{vid: 1'b0, cin: 24'hFFFFFF, exp: 24'h000000};
    vecs[5] = '{vid: 1'b1, cin: 24'h000001, exp: 24'h000001};

    reset = 1'b1;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    frame_start = 1'b0;
    video_on = 1'b0;
    auto_en = 1'b0;
    color_in = '0;
    tick(3);
    chk("rst_sel", 32'(selection), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_switched", 32'(switched), 32'd0);
    chk("rst_color", 32'(color_out), 32'd0);
    reset = 1'b0;
    tick(1);

    // Held press queues, commit waits for frame_start
    btn_next = 1'b1;
    tick(6);
    chk("hold_pending", 32'(pending), 32'd1);
    btn_next = 1'b0;
    tick(8);
    chk("hold_sel_before_frame", 32'(selection), 32'd0);
    commit_frame("next1", 2'd1);

    press(1'b1, 1'b0, 3);
    chk("glitch_pending", 32'(pending), 32'd0);
    chk("glitch_sel", 32'(selection), 32'd1);

    // Modulo wrap both ways
    press(1'b1, 1'b0, 6);
    commit_frame("next2", 2'd2);
    press(1'b1, 1'b0, 6);
    commit_frame("next3", 2'd3);
    press(1'b1, 1'b0, 6);
    commit_frame("wrap_up", 2'd0);
    press(1'b0, 1'b1, 6);
    commit_frame("wrap_down", 2'd3);
    press(1'b1, 1'b1, 6);
    chk("cancel_pending", 32'(pending), 32'd0);
    pulse_frame();
    chk("cancel_sel", 32'(selection), 32'd3);
    chk("cancel_switched", 32'(switched), 32'd0);

    // Latest request wins
    press(1'b1, 1'b0, 6);
    press(1'b1, 1'b0, 6);
    chk("two_next_pending", 32'(pending), 32'd1);
    commit_frame("two_next", 2'd0);
    press(1'b1, 1'b0, 6);
    press(1'b0, 1'b1, 6);
    commit_frame("next_then_prev", 2'd3);

    // Request coinciding with frame_start in IDLE waits one frame
    btn_next = 1'b1;
    tick(5);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    chk("coincide_pending", 32'(pending), 32'd1);
    chk("coincide_sel", 32'(selection), 32'd3);
    chk("coincide_switched", 32'(switched), 32'd0);
    tick(1);
    btn_next = 1'b0;
    tick(8);
    commit_frame("coincide_next_frame", 2'd0);

    // Colour path scoreboard
    for (int i = 0; i < 6; i++) begin
      video_on = vecs[i].vid;
      color_in = vecs[i].cin;
      sb_q.push_back(vecs[i].exp);
      tick(1);
      exp_c = sb_q.pop_front();
      chk($sformatf("color_vec%0d", i), 32'(color_out), 32'(exp_c));
    end
    video_on = 1'b0;
    color_in = '0;
    tick(1);

    // Auto-advance
    exp_sel = 2'd0;
    auto_en = 1'b1;
    tick(1);
    for (int f = 1; f <= 3; f++) begin
      pulse_frame();
      tick(2);
`ifdef AUTO_CYCLE_EN
      chk($sformatf("auto_pending_f%0d", f), 32'(pending), (f == 3) ? 32'd1 : 32'd0);
`else
      chk($sformatf("auto_pending_f%0d", f), 32'(pending), 32'd0);
`endif
      chk($sformatf("auto_sel_f%0d", f), 32'(selection), 32'(exp_sel));
    end
    pulse_frame();
`ifdef AUTO_CYCLE_EN
    exp_sel = 2'd1;
    chk("auto_switched_f4", 32'(switched), 32'd1);
`else
    chk("auto_switched_f4", 32'(switched), 32'd0);
`endif
    chk("auto_sel_f4", 32'(selection), 32'(exp_sel));
    auto_en = 1'b0;
    tick(2);

    // Reset while a request is queued
    press(1'b1, 1'b0, 6);
    commit_frame("pre_reset", exp_sel + 2'd1);
    press(1'b1, 1'b0, 6);
    chk("midwait_pending", 32'(pending), 32'd1);
    video_on = 1'b1;
    color_in = 24'h123456;
    tick(1);
    chk("midwait_color", 32'(color_out), 32'h123456);
    reset = 1'b1;
    tick(1);
    chk("midwait_rst_sel", 32'(selection), 32'd0);
    chk("midwait_rst_pending", 32'(pending), 32'd0);
    chk("midwait_rst_switched", 32'(switched), 32'd0);
    chk("midwait_rst_color", 32'(color_out), 32'd0);
    reset = 1'b0;
    video_on = 1'b0;
    tick(1);
    pulse_frame();
    chk("discarded_sel", 32'(selection), 32'd0);
    chk("discarded_switched", 32'(switched), 32'd0);
    chk("discarded_pending", 32'(pending), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
